ic74595_driver: RTL and testbench

Controller that sequences one or more cascaded 74595 shift-register/output-latch chips from a parallel word. It accepts a word with a start/busy handshake, then serialises it on SER with SRCLK pulses. It finishes with an RCLK latch pulse and manages OE_n and SRCLR_n. It sits between system logic and the ic74595 datapath model or external pins.

---
 rtl/ic74595_pkg.sv | 29 ++
 rtl/ic74595_tick_gen.sv | 29 ++
 rtl/ic74595_driver.sv | 121 ++++++++++++
 tb/tb_ic74595_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ic74595_pkg.sv
// rtl/ic74595_pkg.sv - shared types and constants for the 74595 chain driver
// Purpose : state encoding, chip width and transfer-latency helper used by the
//           driver and its testbench.
// Ports   : none (package).
// Config  : IC74595_CLEAR_EN adds the CLR / CLR_LATCH states.
package ic74595_pkg;

  localparam int CHIP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_FINISH   = 3'd5
`ifdef IC74595_CLEAR_EN
    ,
    ST_CLR       = 3'd6,
    ST_CLR_LATCH = 3'd7
`endif
  } state_t;

  // Cycles from the edge that accepts start to the edge that raises done.
  function automatic int xfer_latency(input int chain, input int clk_div);
    return 2 + 2 * clk_div * CHIP_W * chain + clk_div;
  endfunction

endpackage

// File: rtl/ic74595_tick_gen.sv
// rtl/ic74595_tick_gen.sv - phase divider for the 74595 driver
// Purpose : counts 0..CLK_DIV-1 and flags the last cycle of a phase.
// Ports   : clk, reset (sync, active-high), i_clear (restart count at 0),
//           o_phase_end (high while the count sits at CLK_DIV-1).
module ic74595_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_phase_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_phase_end = (r_cnt == LAST);

endmodule

// File: rtl/ic74595_driver.sv
// rtl/ic74595_driver.sv - serialiser/latch sequencer for cascaded 74595 chips
// Purpose : accepts a parallel word on start, shifts it out on ser with srclk
//           pulses, then pulses rclk and enables the outputs.
// Ports   : clk, reset (sync, active-high), start, data_in[8*CHAIN-1:0],
//           clr (only with IC74595_CLEAR_EN), busy, done, ser, srclk, rclk,
//           srclr_n, oe_n.
// Config  : IC74595_CLEAR_EN adds the clr input and a clear-and-latch sequence.
module ic74595_driver
  import ic74595_pkg::*;
#(
  parameter int CHAIN     = 1,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CHIP_W*CHAIN-1:0] data_in,
`ifdef IC74595_CLEAR_EN
  input  logic                    clr,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    ser,
  output logic                    srclk,
  output logic                    rclk,
  output logic                    srclr_n,
  output logic                    oe_n
);

  localparam int W  = CHIP_W * CHAIN;
  localparam int BW = $clog2(W + 1);

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_shift;
  logic [BW-1:0]   r_bits;
  logic            r_oe_n;
  logic            w_phase_end;
  logic            w_tick_clr;

  // Every state starts its phase with a fresh count.
  assign w_tick_clr = (w_next != r_state);

  ic74595_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_tick_clr),
    .o_phase_end (w_phase_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef IC74595_CLEAR_EN
        if (clr) w_next = ST_CLR;
        else
`endif
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD:     w_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_phase_end) w_next = ST_SHIFT_HI;
      // r_bits still counts the bit on the wire, so 1 means it was the last.
      ST_SHIFT_HI: if (w_phase_end) w_next = (r_bits == BW'(1)) ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH:    if (w_phase_end) w_next = ST_FINISH;
      ST_FINISH:   w_next = ST_IDLE;
`ifdef IC74595_CLEAR_EN
      ST_CLR:       if (w_phase_end) w_next = ST_CLR_LATCH;
      ST_CLR_LATCH: if (w_phase_end) w_next = ST_FINISH;
`endif
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_bits  <= '0;
      r_oe_n  <= 1'b1;
    end else begin
      if ((r_state == ST_IDLE) && (w_next == ST_LOAD)) begin
        r_shift <= data_in;
        r_bits  <= BW'(W);
      end
      // Shift only as srclk falls so ser is stable through the high phase.
      if ((r_state == ST_SHIFT_HI) && w_phase_end) begin
        r_bits <= r_bits - 1'b1;
        if (w_next == ST_SHIFT_LO) begin
          r_shift <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
        end
      end
      // Only a completed data latch enables the outputs; a clear leaves oe_n.
      if ((r_state == ST_LATCH) && w_phase_end) begin
        r_oe_n <= 1'b0;
      end
    end
  end

  assign busy  = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign done  = (r_state == ST_FINISH);
  assign srclk = (r_state == ST_SHIFT_HI);
  assign ser   = MSB_FIRST ? r_shift[W-1] : r_shift[0];
  assign oe_n  = r_oe_n;
`ifdef IC74595_CLEAR_EN
  assign rclk    = (r_state == ST_LATCH) || (r_state == ST_CLR_LATCH);
  assign srclr_n = (r_state != ST_CLR);
`else
  assign rclk    = (r_state == ST_LATCH);
  assign srclr_n = 1'b1;
`endif

endmodule

// File: tb/tb_ic74595_driver.sv
// tb/tb_ic74595_driver.sv - self-checking bench for ic74595_driver
// Purpose : drives two driver configurations (8-bit MSB-first /4 and 16-bit
//           LSB-first /1), scoreboards the serial stream and checks timing.
// Ports   : none (top-level bench).
// Config  : IC74595_CLEAR_EN enables the clear-sequence steps.
module tb_ic74595_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_start;
  logic [7:0]  a_data;
  logic        a_busy, a_done, a_ser, a_srclk, a_rclk, a_srclr_n, a_oe_n;
  logic        b_reset, b_start;
  logic [15:0] b_data;
  logic        b_busy, b_done, b_ser, b_srclk, b_rclk, b_srclr_n, b_oe_n;
`ifdef IC74595_CLEAR_EN
  logic        a_clr;
  logic        b_clr;
`endif

  ic74595_driver #(.CHAIN(1), .CLK_DIV(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(a_reset), .start(a_start), .data_in(a_data),
`ifdef IC74595_CLEAR_EN
    .clr(a_clr),
`endif
    .busy(a_busy), .done(a_done), .ser(a_ser), .srclk(a_srclk),
    .rclk(a_rclk), .srclr_n(a_srclr_n), .oe_n(a_oe_n)
  );

  ic74595_driver #(.CHAIN(2), .CLK_DIV(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(b_reset), .start(b_start), .data_in(b_data),
`ifdef IC74595_CLEAR_EN
    .clr(b_clr),
`endif
    .busy(b_busy), .done(b_done), .ser(b_ser), .srclk(b_srclk),
    .rclk(b_rclk), .srclr_n(b_srclr_n), .oe_n(b_oe_n)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit qa[$];
  bit qb[$];

  logic a_srclk_q = 1'b0, a_ser_q = 1'b0, a_rclk_q = 1'b0;
  logic b_srclk_q = 1'b0, b_ser_q = 1'b0, b_rclk_q = 1'b0;
  int   a_rpulses = 0, a_rwidth = 0, a_rcur = 0, a_done_cnt = 0;
  int   b_rpulses = 0, b_rwidth = 0, b_rcur = 0, b_done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: wait for the sampling edge, then scoreboard both chains.
  task automatic tick();
    bit e;
    @(negedge clk);
    if (a_srclk && !a_srclk_q) begin
      check("a_shift_expected", 32'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_ser_at_srclk", a_ser, e);
      end
    end
    if (a_srclk) check("a_srclk_rclk_excl", a_rclk, 0);
    if (a_srclk && a_srclk_q) check("a_ser_stable", a_ser, a_ser_q);
    if (a_done) a_done_cnt++;
    if (a_rclk) a_rcur++;
    if (!a_rclk && a_rclk_q) begin a_rpulses++; a_rwidth = a_rcur; a_rcur = 0; end

    if (b_srclk && !b_srclk_q) begin
      check("b_shift_expected", 32'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_ser_at_srclk", b_ser, e);
      end
    end
    if (b_srclk) check("b_srclk_rclk_excl", b_rclk, 0);
    if (b_srclk && b_srclk_q) check("b_ser_stable", b_ser, b_ser_q);
    if (b_done) b_done_cnt++;
    if (b_rclk) b_rcur++;
    if (!b_rclk && b_rclk_q) begin b_rpulses++; b_rwidth = b_rcur; b_rcur = 0; end

    a_srclk_q = a_srclk; a_ser_q = a_ser; a_rclk_q = a_rclk;
    b_srclk_q = b_srclk; b_ser_q = b_ser; b_rclk_q = b_rclk;
  endtask

  task automatic run_a(input logic [7:0] d, input int lat);
    int n;
    int p0;
    for (int i = 7; i >= 0; i--) qa.push_back(d[i]);
    p0 = a_rpulses;
    a_data  = d;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_busy_load", a_busy, 1);
    n = 1;
    while (!a_done && n < 500) begin tick(); n++; end
    check("a_latency", n, lat);
    check("a_all_bits_shifted", qa.size(), 0);
    check("a_rclk_pulses", a_rpulses - p0, 1);
    check("a_rclk_width", a_rwidth, 4);
    check("a_oe_n_finish", a_oe_n, 0);
    tick();
    check("a_done_one_cycle", a_done, 0);
    check("a_busy_after", a_busy, 0);
  endtask

  initial begin
    int n;
    int rises;
    logic pv;
    int p0;
    int d0;

    a_reset = 1'b1; a_start = 1'b0; a_data = '0;
    b_reset = 1'b1; b_start = 1'b0; b_data = '0;
`ifdef IC74595_CLEAR_EN
    a_clr = 1'b0; b_clr = 1'b0;
`endif

    // Reset held three cycles, then idle outputs.
    repeat (3) tick();
    a_reset = 1'b0; b_reset = 1'b0;
    tick();
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_srclk", a_srclk, 0);
    check("rst_rclk", a_rclk, 0);
    check("rst_srclr_n", a_srclr_n, 1);
    check("rst_oe_n", a_oe_n, 1);
    check("rst_ser", a_ser, 0);
    check("rst_b_oe_n", b_oe_n, 1);

    // 8'hA5 MSB-first, CLK_DIV=4: 70-cycle transfer.
    run_a(8'hA5, 70);

    // 16'h8001 LSB-first, CLK_DIV=1 on the two-chip chain.
    for (int i = 0; i < 16; i++) qb.push_back(b_data[i] | ((i == 0) || (i == 15)));
    p0 = b_rpulses;
    b_data  = 16'h8001;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 1;
    while (!b_done && n < 500) begin tick(); n++; end
    check("b_latency", n, 35);
    check("b_all_bits_shifted", qb.size(), 0);
    check("b_rclk_pulses", b_rpulses - p0, 1);
    check("b_rclk_width", b_rwidth, 1);
    check("b_oe_n_finish", b_oe_n, 0);
    tick();
    check("b_busy_after", b_busy, 0);

    // 8'h00 accepted, then start toggled with 8'hFF while busy and in FINISH.
    for (int i = 0; i < 8; i++) qa.push_back(1'b0);
    d0 = a_done_cnt;
    a_data  = 8'h00;
    a_start = 1'b1;
    tick();
    a_data = 8'hFF;
    n = 1;
    while (!a_done && n < 500) begin a_start = n[0]; tick(); n++; end
    check("a_busy_latency", n, 70);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (100) tick();
    check("a_single_done", a_done_cnt - d0, 1);
    check("a_no_second_xfer", a_busy, 0);
    check("a_busy_queue_empty", qa.size(), 0);

    // Reset during the third srclk-high phase aborts the transfer.
    for (int i = 7; i >= 0; i--) qa.push_back(1'(8'h3C >> i));
    a_data  = 8'h3C;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    rises = 0; n = 0; pv = 1'b0;
    while (rises < 3 && n < 500) begin
      tick(); n++;
      if (a_srclk && !pv) rises++;
      pv = a_srclk;
    end
    check("a_reached_bit3_hi", rises, 3);
    check("a_in_shift_hi", a_srclk, 1);
    p0 = a_rpulses;
    d0 = a_done_cnt;
    a_reset = 1'b1;
    tick();
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_srclk", a_srclk, 0);
    check("abort_rclk", a_rclk, 0);
    check("abort_ser", a_ser, 0);
    check("abort_srclr_n", a_srclr_n, 1);
    check("abort_oe_n", a_oe_n, 1);
    a_reset = 1'b0;
    qa.delete();
    repeat (80) tick();
    check("abort_no_rclk", a_rpulses - p0, 0);
    check("abort_no_done", a_done_cnt - d0, 0);
    run_a(8'h5A, 70);

`ifdef IC74595_CLEAR_EN
    // clr and start together: clear sequence wins, start dropped.
    p0 = a_rpulses;
    a_data  = 8'hFF;
    a_clr   = 1'b1;
    a_start = 1'b1;
    tick();
    a_clr   = 1'b0;
    a_start = 1'b0;
    n = 0;
    while (!a_srclr_n && n < 50) begin check("clr_busy_lo", a_busy, 1); n++; tick(); end
    check("clr_srclr_width", n, 4);
    n = 0;
    while (a_rclk && n < 50) begin check("clr_busy_latch", a_busy, 1); n++; tick(); end
    check("clr_rclk_width", n, 4);
    check("clr_done", a_done, 1);
    check("clr_oe_n_kept", a_oe_n, 0);
    repeat (100) tick();
    check("clr_start_dropped", a_busy, 0);
    check("clr_one_rclk", a_rpulses - p0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
